// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM-to-stream burst reader.
package ram_stream_reader_pkg;

  localparam int unsigned RAM_READ_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAPTURE,
    SEND,
    FINISH
  } state_t;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Valid/ready stream from the burst reader to the downstream transmitter.
interface ram_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// Reads a burst of words from a synchronous RAM and emits them on a valid/ready stream.
// Optional feature: define RAM_STREAM_READER_CHECKSUM_EN to append an XOR checksum word.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  ram_stream_reader_if.master   tx,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  // ADDR -> CAPTURE sequencing assumes exactly one cycle of RAM read latency.
  if (RAM_READ_LATENCY != 1) begin : g_latency_check
    $error("ram_stream_reader requires RAM_READ_LATENCY == 1");
  end

  state_t                state;
  logic [CNT_W-1:0]      remaining;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic                  xfer_c;

`ifdef RAM_STREAM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
  logic                  csum_phase;
`endif

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign xfer_c      = tx_valid_q && tx.tx_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      read_addr  <= '0;
      remaining  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            read_addr <= start_addr;
            remaining <= length;
            busy      <= 1'b1;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
            csum <= '0;
            // An empty burst still carries its (zero) checksum word.
            if (length == '0) begin
              tx_data_q  <= '0;
              tx_valid_q <= 1'b1;
              csum_phase <= 1'b1;
              state      <= SEND;
            end else begin
              state <= ADDR;
            end
`else
            if (length == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              state <= ADDR;
            end
`endif
          end
        end
        ADDR: state <= CAPTURE;
        CAPTURE: begin
          tx_data_q  <= q;
          tx_valid_q <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (xfer_c) begin
            tx_valid_q <= 1'b0;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
            if (csum_phase) begin
              csum_phase <= 1'b0;
              done       <= 1'b1;
              state      <= FINISH;
            end else if (remaining > CNT_W'(1)) begin
              csum      <= csum ^ tx_data_q;
              read_addr <= read_addr + ADDR_WIDTH'(1);
              remaining <= remaining - CNT_W'(1);
              state     <= ADDR;
            end else begin
              // Last data word accepted: present the checksum back-to-back.
              tx_data_q  <= csum ^ tx_data_q;
              tx_valid_q <= 1'b1;
              csum_phase <= 1'b1;
              remaining  <= '0;
            end
`else
            if (remaining > CNT_W'(1)) begin
              read_addr <= read_addr + ADDR_WIDTH'(1);
              remaining <= remaining - CNT_W'(1);
              state     <= ADDR;
            end else begin
              remaining <= '0;
              done      <= 1'b1;
              state     <= FINISH;
            end
`endif
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, RAM word and output stream width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, RAM address width (depth 2**ADDR_WIDTH).
REQ-003 The block SHALL have port clock, input, 1, the single clock for all logic and the RAM read port.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle request to begin a burst.
REQ-006 The block SHALL have port start_addr, input, ADDR_WIDTH, first RAM address, sampled with start.
REQ-007 The block SHALL have port length, input, ADDR_WIDTH+1, word count in the range 0..2**ADDR_WIDTH, sampled with start.
REQ-008 The block SHALL have port read_addr, output, ADDR_WIDTH, RAM read address.
REQ-009 The block SHALL have port q, input, DATA_WIDTH, RAM read data, valid one clock after read_addr.
REQ-010 The block SHALL have port tx_data, output, DATA_WIDTH, stream data to the downstream transmitter.
REQ-011 The block SHALL have port tx_valid, output, 1, tx_data holds a word.
REQ-012 The block SHALL have port tx_ready, input, 1, downstream accepts the word.
REQ-013 The block SHALL have port busy, output, 1, burst in progress.
REQ-014 The block SHALL have port done, output, 1, one-cycle pulse at burst end.

Function
REQ-015 The FSM SHALL have the states IDLE, ADDR, CAPTURE, SEND and FINISH.
REQ-016 IDLE: start=1 latches start_addr/length; length=0 goes to FINISH, otherwise to ADDR.
REQ-017 ADDR: read_addr SHALL equal the current address; the next state is CAPTURE (1-cycle RAM latency).
REQ-018 CAPTURE: q is registered into tx_data, tx_valid is set, and the next state is SEND.
REQ-019 SEND: tx_data/tx_valid SHALL be held stable until tx_valid&&tx_ready, which is the transfer.
REQ-020 On a transfer with remaining>1, the address increments, remaining decrements, tx_valid clears, and the next state is ADDR; with remaining==1 the next state is FINISH.
REQ-021 FINISH: done=1 for exactly one cycle and the next state is IDLE; busy is 0 only in IDLE.
REQ-022 The address SHALL wrap modulo 2**ADDR_WIDTH (e.g. start_addr=15, length=3 reads 15,0,1 for ADDR_WIDTH=4).
REQ-023 start while busy=1 SHALL be ignored, with no effect on the burst in progress.
REQ-024 tx_ready held low SHALL stall SEND indefinitely with no data loss or duplication.
REQ-025 Throughput without stalls is one word per 3 cycles; a word SHALL never be emitted twice or skipped.

Reset
REQ-026 Asserting reset_n low SHALL immediately force state IDLE, read_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, and clear the internal counters.
REQ-027 Reset mid-burst SHALL abandon the burst with no done pulse; the next start after reset release SHALL behave normally.

Configuration
REQ-028 With macro RAM_STREAM_READER_CHECKSUM_EN defined, after the last data word and before FINISH the block SHALL emit one extra word: the XOR of all words sent in the burst, using the same handshake.
REQ-029 A length=0 burst SHALL emit a checksum word of 0 when RAM_STREAM_READER_CHECKSUM_EN is defined.
REQ-030 Without RAM_STREAM_READER_CHECKSUM_EN, no checksum logic SHALL exist and bursts emit exactly length words.

Structure
REQ-031 The package ram_stream_reader_pkg SHALL hold the FSM state enum typedef and the constant RAM_READ_LATENCY=1.
REQ-032 There SHALL be no sub-module; the RAM is instantiated outside the block, with read_addr/q wired to its read port and the same clock on the read side.

Verification
REQ-033 start_addr=2, length=4, RAM[a]=a+8'h10, tx_ready=1 -> tx_data 12,13,14,15 (hex), then done pulse, busy low.
REQ-034 start_addr=14, length=3 -> reads addresses 14,15,0, and the output order matches RAM contents.
REQ-035 length=0 -> done on the 2nd cycle after start, tx_valid never asserted (checksum 0 emitted if enabled).
REQ-036 tx_ready low for 10 cycles in SEND -> tx_data stable, then accepted once; the total word count equals length.
REQ-037 start pulsed during a burst, then reset_n low mid-burst -> second start ignored; after reset all outputs are 0 and a new burst of length=2 completes correctly.
REQ-038 With checksum enabled, words 01,02,04 -> 4th word 07, then done.
